// File: rtl/xmint_pkg.sv
// Shared definitions for the xmint memory arbiter slice.
// - owner_e         : identifies which requester owns a granted transaction.
// - MAX_OUT_DEFAULT : default number of outstanding granted transactions.
package xmint_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int unsigned MAX_OUT_DEFAULT = 2;

endpackage

// File: rtl/xmint_owner_fifo.sv
// In-order owner FIFO: records which requester owns each outstanding
// transaction so responses can be routed back in grant order.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (empties the FIFO)
//   push_i         : write push_owner_i (ignored when full)
//   push_owner_i   : owner ID to record
//   pop_i          : remove the head entry (ignored when empty)
//   full_o, empty_o: occupancy flags
//   head_o         : owner ID at the head
module xmint_owner_fifo
  import xmint_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUT_DEFAULT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  owner_e push_owner_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_e head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  owner_e          store_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = store_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        store_q[wr_ptr_q] <= push_owner_i;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xmint_mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one shared memory
// port. Round-robin on conflicts, selection locked while a request stalls,
// responses routed back in order through an owner FIFO of depth MAX_OUT.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   instr_*              : instruction request/grant/response channel
//   data_*               : load/store request/grant/response channel
//   mem_*                : shared memory request/grant/response channel
module xmint_mem_arbiter
  import xmint_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  owner_e sel;
  owner_e last_q;
  owner_e locked_owner_q;
  logic   locked_q;
  logic   handshake;
  logic   fifo_full;
  logic   fifo_empty;
  owner_e fifo_head;
  logic   resp_valid;

  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full & ~rst_i;
  assign handshake = mem_req_o & mem_gnt_i;

  // A stalled request keeps its owner until the handshake; otherwise the
  // loser of the previous handshake wins a conflict.
  always_comb begin
    sel = OWNER_INSTR;
    if (locked_q) begin
      sel = locked_owner_q;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    end else if (data_req_i) begin
      sel = OWNER_DATA;
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (sel == OWNER_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = handshake & (sel == OWNER_INSTR);
  assign data_gnt_o  = handshake & (sel == OWNER_DATA);

  // Last winner resets to instr so that data wins the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q       <= 1'b0;
      locked_owner_q <= OWNER_INSTR;
      last_q         <= OWNER_INSTR;
    end else if (handshake) begin
      locked_q <= 1'b0;
      last_q   <= sel;
    end else if (mem_req_o) begin
      locked_q       <= 1'b1;
      locked_owner_q <= sel;
    end
  end

  xmint_owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (handshake),
    .push_owner_i (sel),
    .pop_i        (resp_valid),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (fifo_head)
  );

  // Responses with no outstanding owner are dropped.
  assign resp_valid     = mem_rvalid_i & ~fifo_empty & ~rst_i;
  assign instr_rvalid_o = resp_valid & (fifo_head == OWNER_INSTR);
  assign data_rvalid_o  = resp_valid & (fifo_head == OWNER_DATA);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_xmint_mem_arbiter.sv
// Directed self-checking bench for xmint_mem_arbiter (MAX_OUT = 2).
module tb_xmint_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  xmint_mem_arbiter #(
    .MAX_OUT (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req),
    .instr_gnt_o    (instr_gnt),
    .instr_addr_i   (instr_addr),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .mem_err_i      (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there and
  // outputs are checked mid-cycle via settle().
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    instr_req  = 1'b0;
    instr_addr = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = '0;
    data_wdata = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Per-cycle stimulus for the conflict run: grant owner and response owner.
  logic       exp_dgnt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       exp_drv  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       rv_on    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    idle_inputs();
    rst = 1'b1;
    next_cycle();

    // Reset: outputs suppressed even with requests and a response present.
    instr_req  = 1'b1;
    data_req   = 1'b1;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    settle();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_gnt", 32'({instr_gnt, data_gnt}), 32'd0);
    check("rst_rvalid", 32'({instr_rvalid, data_rvalid}), 32'd0);
    do_reset();

    // Single instruction request, response two cycles later.
    instr_req  = 1'b1;
    instr_addr = 32'h100;
    mem_gnt    = 1'b1;
    settle();
    check("s_mem_req", 32'(mem_req), 32'd1);
    check("s_igrant", 32'({instr_gnt, data_gnt}), 32'b10);
    check("s_addr", mem_addr, 32'h100);
    check("s_we_be", 32'({mem_we, mem_be}), 32'h0F);
    check("s_wdata", mem_wdata, 32'h0);
    next_cycle();
    idle_inputs();
    next_cycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    settle();
    check("s_irvalid", 32'({instr_rvalid, data_rvalid}), 32'b10);
    check("s_rdata", instr_rdata, 32'hA5A5A5A5);
    check("s_ierr", 32'(instr_err), 32'd0);
    next_cycle();
    idle_inputs();

    // Conflict: data first after reset, then alternating; in-order responses.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      instr_req  = (i < 4);
      data_req   = (i < 4);
      instr_addr = 32'h1000 + 32'(i);
      data_addr  = 32'h2000 + 32'(i);
      mem_gnt    = (i < 4);
      mem_rvalid = rv_on[i];
      mem_rdata  = 32'hD0 + 32'(i);
      settle();
      if (i < 4) begin
        check($sformatf("c_dgnt%0d", i), 32'(data_gnt), 32'(exp_dgnt[i]));
        check($sformatf("c_ignt%0d", i), 32'(instr_gnt), 32'(!exp_dgnt[i]));
        check($sformatf("c_addr%0d", i), mem_addr,
              exp_dgnt[i] ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i));
      end
      if (rv_on[i]) begin
        check($sformatf("c_drv%0d", i), 32'(data_rvalid), 32'(exp_drv[i]));
        check($sformatf("c_irv%0d", i), 32'(instr_rvalid), 32'(!exp_drv[i]));
      end
      next_cycle();
    end
    idle_inputs();

    // Stall: data store waits 3 cycles while instr rises; instr served next.
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'hF;
    data_addr  = 32'h200;
    data_wdata = 32'hCAFEBABE;
    for (int i = 0; i < 3; i++) begin
      instr_req  = (i > 0);
      instr_addr = 32'h300;
      settle();
      check($sformatf("st_req%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("st_addr%0d", i), mem_addr, 32'h200);
      check($sformatf("st_we%0d", i), 32'(mem_we), 32'd1);
      check($sformatf("st_wd%0d", i), mem_wdata, 32'hCAFEBABE);
      check($sformatf("st_gnt%0d", i), 32'({instr_gnt, data_gnt}), 32'b00);
      next_cycle();
    end
    mem_gnt = 1'b1;
    settle();
    check("st_dgnt", 32'({instr_gnt, data_gnt}), 32'b01);
    check("st_addr_g", mem_addr, 32'h200);
    next_cycle();
    data_req = 1'b0;
    settle();
    check("st_ignt", 32'({instr_gnt, data_gnt}), 32'b10);
    check("st_iaddr", mem_addr, 32'h300);
    check("st_iwe", 32'(mem_we), 32'd0);
    next_cycle();
    idle_inputs();
    mem_rvalid = 1'b1;
    settle();
    check("st_rv0", 32'({instr_rvalid, data_rvalid}), 32'b01);
    next_cycle();
    settle();
    check("st_rv1", 32'({instr_rvalid, data_rvalid}), 32'b10);
    next_cycle();
    idle_inputs();

    // Full: two grants, third request blocked until a response drains one.
    do_reset();
    data_req = 1'b1;
    mem_gnt  = 1'b1;
    settle();
    check("f_g0", 32'(data_gnt), 32'd1);
    next_cycle();
    data_req  = 1'b0;
    instr_req = 1'b1;
    settle();
    check("f_g1", 32'(instr_gnt), 32'd1);
    next_cycle();
    instr_req = 1'b0;
    data_req  = 1'b1;
    settle();
    check("f_full_req", 32'(mem_req), 32'd0);
    check("f_full_gnt", 32'({instr_gnt, data_gnt}), 32'b00);
    next_cycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11;
    settle();
    check("f_pop", 32'({instr_rvalid, data_rvalid}), 32'b01);
    next_cycle();
    mem_rvalid = 1'b0;
    settle();
    check("f_reopen_req", 32'(mem_req), 32'd1);
    check("f_reopen_gnt", 32'(data_gnt), 32'd1);
    next_cycle();
    // FIFO now holds instr, then data (pointers have wrapped).
    idle_inputs();
    mem_rvalid = 1'b1;
    settle();
    check("e_irv", 32'({instr_rvalid, data_rvalid}), 32'b10);
    next_cycle();
    mem_err = 1'b1;
    settle();
    check("e_drv", 32'({instr_rvalid, data_rvalid}), 32'b01);
    check("e_derr", 32'(data_err), 32'd1);
    check("e_ierr", 32'(instr_err), 32'd0);
    next_cycle();
    settle();
    check("e_empty_rv", 32'({instr_rvalid, data_rvalid}), 32'b00);
    check("e_empty_err", 32'({instr_err, data_err}), 32'b00);
    next_cycle();
    idle_inputs();

    // Orphan: reset with two outstanding, later response is dropped.
    data_req  = 1'b1;
    instr_req = 1'b1;
    mem_gnt   = 1'b1;
    next_cycle();
    next_cycle();
    idle_inputs();
    do_reset();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    settle();
    check("o_rv", 32'({instr_rvalid, data_rvalid}), 32'b00);
    check("o_req", 32'(mem_req), 32'd0);
    next_cycle();
    idle_inputs();
    // Reset cleared occupancy: two fresh grants are accepted.
    data_req = 1'b1;
    mem_gnt  = 1'b1;
    settle();
    check("o_g0", 32'(data_gnt), 32'd1);
    next_cycle();
    settle();
    check("o_g1", 32'(data_gnt), 32'd1);
    next_cycle();
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
